reset_sequencer: RTL

Central reset request and release controller that produces the staged, active-low reset outputs consumed by per-domain reset synchronizers. It merges synchronous reset requests from several sources into one reset event. It enforces a minimum assertion width, then releases the downstream domains one at a time in index order, with a fixed spacing between releases. It reports the cause of each event and a one-cycle completion pulse.

---
 rtl/reset_seq_pkg.sv | 34 +++
 rtl/reset_seq_wdt.sv | 29 ++
 rtl/reset_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state codes, cause index,
// and parameter helpers.
package reset_seq_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE    = 2'd0;
    localparam seq_state_t ST_ASSERT  = 2'd1;
    localparam seq_state_t ST_RELEASE = 2'd2;

    // The watchdog cause bit sits just above the request source bits.
    function automatic int cause_wdt(input int num_src);
        return num_src;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit params_ok(
        input int num_src,
        input int num_dom,
        input int assert_cyc,
        input int stagger_cyc,
        input int wdt_timeout
    );
        return (num_src >= 1) && (num_dom >= 1) &&
               (assert_cyc >= 1) && (stagger_cyc >= 1) &&
               (wdt_timeout >= 1);
    endfunction

endpackage

// File: rtl/reset_seq_wdt.sv
// Watchdog for the reset sequencer: counts idle cycles without a kick
// and emits a one-cycle expiry request.
module reset_seq_wdt #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    input  logic kick,
    output logic expire
);

    logic [CW-1:0] cnt;

    assign expire = run && !kick && (cnt == CW'(TIMEOUT - 1));

    // Counter is held at zero outside idle, so entry to idle starts fresh.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!run || kick || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset request/release controller with sticky cause reporting.
// Optional watchdog request source enabled by RESET_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int NUM_DOMAINS    = 3,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDT_TIMEOUT    = 1024
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_SRC-1:0]     req,
    input  logic                   cause_clr,
    input  logic                   wdt_kick,
    output logic [NUM_DOMAINS-1:0] rst_out_n,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_SRC:0]       cause
);

    localparam int CW = $clog2(max3(ASSERT_CYCLES, STAGGER_CYCLES,
                                    WDT_TIMEOUT) + 1);
    localparam int DW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int CI = cause_wdt(NUM_SRC);

    localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DOMAINS - 1);

    if (!params_ok(NUM_SRC, NUM_DOMAINS, ASSERT_CYCLES,
                   STAGGER_CYCLES, WDT_TIMEOUT)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter values");
    end

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dom_idx;
    logic          por_pend;
    logic          wdt_exp;
    logic [NUM_SRC:0] req_bits;
    logic          req_any;

`ifdef RESET_SEQ_WDT_EN
    reset_seq_wdt #(
        .TIMEOUT (WDT_TIMEOUT),
        .CW      (CW)
    ) u_wdt (
        .clock   (clock),
        .resetn  (resetn),
        .run     (state == ST_IDLE),
        .kick    (wdt_kick),
        .expire  (wdt_exp)
    );
`else
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
    assign wdt_exp = 1'b0;
`endif

    // Merge source requests and the watchdog into one cause vector.
    always_comb begin
        req_bits = '0;
        req_bits[NUM_SRC-1:0] = req;
        req_bits[CI] = wdt_exp;
    end

    assign req_any = |req_bits;

    // Sequencer: the first edge out of reset acts like a request so the
    // power-on schedule matches the request schedule.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            dom_idx   <= '0;
            por_pend  <= 1'b1;
            rst_out_n <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (req_any || por_pend) begin
                por_pend  <= 1'b0;
                state     <= ST_ASSERT;
                cnt       <= '0;
                dom_idx   <= '0;
                rst_out_n <= '0;
                busy      <= 1'b1;
            end else begin
                unique case (state)
                    ST_ASSERT: begin
                        if (cnt == A_LAST) begin
                            rst_out_n[0] <= 1'b1;
                            cnt          <= '0;
                            if (NUM_DOMAINS == 1) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state   <= ST_RELEASE;
                                dom_idx <= DW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == S_LAST) begin
                            rst_out_n[dom_idx] <= 1'b1;
                            cnt                <= '0;
                            if (dom_idx == D_LAST) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                dom_idx <= dom_idx + DW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Sticky cause; a clear coinciding with a request keeps only new bits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cause <= '0;
        end else if (cause_clr) begin
            cause <= req_bits;
        end else begin
            cause <= cause | req_bits;
        end
    end

endmodule
